// File: rtl/mm_pkg.sv
// Shared definitions for the banked result memory: bank geometry helpers,
// lane type and the drain FSM state encoding.
package mm_pkg;

  localparam int LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

  function automatic int bank_depth(input int m, input int n);
    return (m * m) / n;
  endfunction

  function automatic int bank_aw(input int m, input int n);
    int d;
    d = bank_depth(m, n);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/mem_drain_if.sv
// BRAM read port plus downstream beat stream of the drain stage.
// master = drain side, slave = memory banks / consumer side.
interface mem_drain_if #(
  parameter int D_W = 8,
  parameter int N   = 3,
  parameter int AW  = 4
);

  logic [N-1:0][AW-1:0]  rd_addr_bram;
  logic [N-1:0]          rd_en_bram;
  logic [N-1:0][D_W-1:0] rd_data_bram;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0][D_W-1:0] out_data;
  logic                  out_last;

  modport master (
    output rd_addr_bram, rd_en_bram, out_valid, out_data, out_last,
    input  rd_data_bram, out_ready
  );

  modport slave (
    input  rd_addr_bram, rd_en_bram, out_valid, out_data, out_last,
    output rd_data_bram, out_ready
  );

endinterface

// File: rtl/mem_drain_skid.sv
// Small synchronous FIFO that absorbs BRAM read latency; head is registered
// storage so the consumer never sees a combinational path from the banks.
module mem_drain_skid #(
  parameter int W     = 24,
  parameter int DEPTH = 3,
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  head_o,
  output logic [OW-1:0] occ_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop_i) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
    occ_d = occ_q + OW'(push_i) - OW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  assign valid_o = (occ_q != '0);
  assign head_o  = mem_q[rd_q];
  assign occ_o   = occ_q;

  // The issue-credit rule in the parent must keep a full FIFO from being written.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst)
    !(push_i && !pop_i && (occ_q == OW'(DEPTH))));

endmodule

// File: rtl/mem_drain.sv
// Drains all N result banks in lock-step, one N-lane beat per address.
// Optional feature macro: MEM_DRAIN_LAST_EN adds an out_last flag on the final beat.
module mem_drain
  import mm_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int N      = 3,
  parameter int M      = 6,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  mem_drain_if.master bus
);

  localparam int DEPTH = bank_depth(M, N);
  localparam int AW    = bank_aw(M, N);
  localparam int SKID  = RD_LAT + 2;
  localparam int OW    = $clog2(SKID + 1);
  localparam int DW    = N * D_W;
`ifdef MEM_DRAIN_LAST_EN
  localparam int FW    = DW + 1;
`else
  localparam int FW    = DW;
`endif

  drain_state_e      state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic              issue, push, pop, fifo_valid, at_end;
  logic [OW-1:0]     occ;
  logic [FW-1:0]     push_data, head;
  int                inflight;

  assign at_end = (addr_q == AW'(DEPTH - 1));
  assign push   = infl_q[RD_LAT-1];
  assign pop    = fifo_valid & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    issue    = 1'b0;
    done     = 1'b0;
    inflight = $countones(infl_q);
    case (state_q)
      IDLE: if (start) state_d = READ;
      READ: begin
        // Credit counts every word already owed to the FIFO, net of this cycle's pop.
        if (int'(occ) + inflight - int'(pop) < SKID) begin
          issue  = 1'b1;
          addr_d = at_end ? '0 : addr_q + AW'(1);
          if (at_end) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == '0 && inflight == 0) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    infl_d = (infl_q << 1) | RD_LAT'(issue);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      infl_q  <= infl_d;
    end
  end

`ifdef MEM_DRAIN_LAST_EN
  logic [RD_LAT-1:0] last_infl_q, last_infl_d;

  assign last_infl_d = (last_infl_q << 1) | RD_LAT'(issue & at_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_infl_q <= '0;
    else      last_infl_q <= last_infl_d;
  end

  assign push_data    = {last_infl_q[RD_LAT-1], bus.rd_data_bram};
  assign bus.out_last = head[DW];
`else
  assign push_data    = bus.rd_data_bram;
  assign bus.out_last = 1'b0;
`endif

  mem_drain_skid #(
    .W     (FW),
    .DEPTH (SKID),
    .OW    (OW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .head_o  (head),
    .occ_o   (occ)
  );

  assign bus.rd_en_bram   = {N{issue}};
  assign bus.rd_addr_bram = {N{addr_q}};
  assign bus.out_valid    = fifo_valid;
  assign bus.out_data     = head[DW-1:0];
  assign busy             = (state_q != IDLE);

endmodule
